// File: rtl/design_sel_ctrl_pkg.sv
// Shared types and sizes for the design-select sequencer and its Wishbone register block.
package design_sel_ctrl_pkg;

   localparam int unsigned NUM_DESIGNS = 16;
   localparam int unsigned ID_W        = 4;
   localparam int unsigned CNT_W       = 8;
   localparam int unsigned SWC_W       = 16;
   localparam int unsigned WB_DW       = 32;
   localparam int unsigned WB_AW       = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HOLD   = 3'd1,
      ST_SETUP  = 3'd2,
      ST_CLKHI  = 3'd3,
      ST_CLKLO  = 3'd4,
      ST_SETTLE = 3'd5
   } state_t;

   // CTRL readback layout
   typedef struct packed {
      logic [18:0]     rsvd_hi;
      logic            cur_valid;
      logic            pending;
      logic            busy;
      logic [1:0]      rsvd_lo;
      logic [ID_W-1:0] req_id;
      logic [ID_W-1:0] cur_id;
   } ctrl_rd_t;

endpackage

// File: rtl/design_sel_ctrl_wb_regs.sv
// Wishbone slave for the design-select sequencer: decode, single-cycle ack, request latch, readback.
// DSEL_LA_OVERRIDE_EN adds a logic-analyzer request input that behaves like a CTRL write.
module design_sel_ctrl_wb_regs
   import design_sel_ctrl_pkg::*;
#(
   parameter logic [WB_AW-1:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cyc,
   input  logic             stb,
   input  logic             we,
   input  logic [3:0]       sel,
   input  logic [WB_AW-1:0] adr,
   input  logic [WB_DW-1:0] wdat,
   output logic             ack,
   output logic [WB_DW-1:0] rdat,
   input  logic             take_c,
   input  logic             busy,
   input  logic             cur_valid,
   input  logic [ID_W-1:0]  cur_id,
   input  logic [SWC_W-1:0] switch_count,
   output logic [ID_W-1:0]  req_id,
   output logic             pending
`ifdef DSEL_LA_OVERRIDE_EN
   ,
   input  logic             la_sel_req,
   input  logic [ID_W-1:0]  la_sel_id
`endif
);

   logic             hit_c;
   logic             acc_c;
   logic             ctrl_wr_c;
   logic             req_wr_c;
   logic [ID_W-1:0]  req_dat_c;
   ctrl_rd_t         ctrl_c;
   logic [WB_DW-1:0] rd_c;
   logic             unused_c;

   assign hit_c     = cyc & stb & (adr[WB_AW-1:3] == BASE_ADDR[WB_AW-1:3]);
   // an ack cycle blocks acceptance so acks are never back-to-back
   assign acc_c     = hit_c & ~ack;
   assign ctrl_wr_c = acc_c & we & ~adr[2] & sel[0];
   assign unused_c  = ^{adr[1:0], wdat[WB_DW-1:ID_W], sel[3:1]};

`ifdef DSEL_LA_OVERRIDE_EN
   logic la_req_q;
   logic la_edge_c;

   assign la_edge_c = la_sel_req & ~la_req_q;

   always_ff @(posedge clk) begin
      if (rst) la_req_q <= 1'b0;
      else     la_req_q <= la_sel_req;
   end

   // Wishbone write wins over a coincident LA request
   always_comb begin
      req_wr_c  = ctrl_wr_c | la_edge_c;
      req_dat_c = ctrl_wr_c ? wdat[ID_W-1:0] : la_sel_id;
   end
`else
   always_comb begin
      req_wr_c  = ctrl_wr_c;
      req_dat_c = wdat[ID_W-1:0];
   end
`endif

   always_comb begin
      ctrl_c           = '0;
      ctrl_c.cur_valid = cur_valid;
      ctrl_c.pending   = pending;
      ctrl_c.busy      = busy;
      ctrl_c.req_id    = req_id;
      ctrl_c.cur_id    = cur_id;
      rd_c             = adr[2] ? {16'h0, switch_count} : WB_DW'(ctrl_c);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ack     <= 1'b0;
         rdat    <= '0;
         req_id  <= '0;
         pending <= 1'b0;
      end else begin
         ack  <= acc_c;
         rdat <= (acc_c & ~we) ? rd_c : '0;
         // a new request in the same cycle the sequencer takes the old one stays pending
         if (req_wr_c) begin
            req_id  <= req_dat_c;
            pending <= 1'b1;
         end else if (take_c) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/design_sel_ctrl.sv
// Sequencer driving top_design_mux sel_id/sel_clk with reset hold around every design switch.
// Optional build macro: DSEL_LA_OVERRIDE_EN (LA-side request inputs).
module design_sel_ctrl
   import design_sel_ctrl_pkg::*;
#(
   parameter logic [WB_AW-1:0] BASE_ADDR     = 32'h3000_0000,
   parameter int unsigned      HOLD_CYCLES   = 8,
   parameter int unsigned      CLK_HI_CYCLES = 4,
   parameter int unsigned      SETTLE_CYCLES = 16
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic                   wbs_cyc_i,
   input  logic                   wbs_stb_i,
   input  logic                   wbs_we_i,
   input  logic [3:0]             wbs_sel_i,
   input  logic [WB_AW-1:0]       wbs_adr_i,
   input  logic [WB_DW-1:0]       wbs_dat_i,
   output logic                   wbs_ack_o,
   output logic [WB_DW-1:0]       wbs_dat_o,
   output logic [ID_W-1:0]        sel_id,
   output logic                   sel_clk,
   output logic [NUM_DESIGNS-1:0] design_rst,
   output logic                   busy
`ifdef DSEL_LA_OVERRIDE_EN
   ,
   input  logic                   la_sel_req,
   input  logic [ID_W-1:0]        la_sel_id
`endif
);

   state_t                 state, state_d;
   logic [CNT_W-1:0]       cnt, cnt_d;
   logic [ID_W-1:0]        tgt, tgt_d;
   logic [ID_W-1:0]        cur_id, cur_id_d;
   logic                   cur_valid, cur_valid_d;
   logic [SWC_W-1:0]       switch_count, switch_count_d;
   logic [ID_W-1:0]        sel_id_d;
   logic                   sel_clk_d;
   logic [NUM_DESIGNS-1:0] design_rst_d;
   logic                   busy_d;
   logic                   take_c;
   logic [ID_W-1:0]        req_id;
   logic                   pending;

   design_sel_ctrl_wb_regs #(
      .BASE_ADDR (BASE_ADDR)
   ) u_regs (
      .clk          (wb_clk_i),
      .rst          (wb_rst_i),
      .cyc          (wbs_cyc_i),
      .stb          (wbs_stb_i),
      .we           (wbs_we_i),
      .sel          (wbs_sel_i),
      .adr          (wbs_adr_i),
      .wdat         (wbs_dat_i),
      .ack          (wbs_ack_o),
      .rdat         (wbs_dat_o),
      .take_c       (take_c),
      .busy         (busy),
      .cur_valid    (cur_valid),
      .cur_id       (cur_id),
      .switch_count (switch_count),
      .req_id       (req_id),
      .pending      (pending)
`ifdef DSEL_LA_OVERRIDE_EN
      ,
      .la_sel_req   (la_sel_req),
      .la_sel_id    (la_sel_id)
`endif
   );

   // sel_clk is reset low so the mux keeps its last latched design across a reset
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         tgt          <= '1;
         cur_id       <= '1;
         cur_valid    <= 1'b0;
         switch_count <= '0;
         sel_id       <= '1;
         sel_clk      <= 1'b0;
         design_rst   <= '1;
         busy         <= 1'b0;
      end else begin
         state        <= state_d;
         cnt          <= cnt_d;
         tgt          <= tgt_d;
         cur_id       <= cur_id_d;
         cur_valid    <= cur_valid_d;
         switch_count <= switch_count_d;
         sel_id       <= sel_id_d;
         sel_clk      <= sel_clk_d;
         design_rst   <= design_rst_d;
         busy         <= busy_d;
      end
   end

   // next-state and registered-output logic; every active phase counts cnt down to zero
   always_comb begin
      state_d        = state;
      cnt_d          = (state == ST_IDLE) ? cnt : cnt - CNT_W'(1);
      tgt_d          = tgt;
      cur_id_d       = cur_id;
      cur_valid_d    = cur_valid;
      switch_count_d = switch_count;
      sel_id_d       = sel_id;
      sel_clk_d      = sel_clk;
      design_rst_d   = design_rst;
      busy_d         = busy;
      take_c         = 1'b0;

      case (state)
         ST_IDLE: begin
            if (pending) begin
               state_d      = ST_HOLD;
               take_c       = 1'b1;
               tgt_d        = req_id;
               design_rst_d = '1;
               busy_d       = 1'b1;
               cnt_d        = CNT_W'(HOLD_CYCLES - 1);
            end
         end
         ST_HOLD: begin
            if (cnt == '0) begin
               state_d  = ST_SETUP;
               sel_id_d = tgt;
               cnt_d    = CNT_W'(CLK_HI_CYCLES - 1);
            end
         end
         ST_SETUP: begin
            if (cnt == '0) begin
               state_d   = ST_CLKHI;
               sel_clk_d = 1'b1;
               cnt_d     = CNT_W'(CLK_HI_CYCLES - 1);
            end
         end
         ST_CLKHI: begin
            if (cnt == '0) begin
               state_d   = ST_CLKLO;
               sel_clk_d = 1'b0;
               cnt_d     = CNT_W'(CLK_HI_CYCLES - 1);
            end
         end
         ST_CLKLO: begin
            if (cnt == '0) begin
               state_d = ST_SETTLE;
               cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
            end
         end
         ST_SETTLE: begin
            if (cnt == '0) begin
               state_d        = ST_IDLE;
               cnt_d          = '0;
               cur_id_d       = tgt;
               cur_valid_d    = 1'b1;
               design_rst_d   = ~(NUM_DESIGNS'(1) << tgt);
               switch_count_d = switch_count + SWC_W'(1);
               busy_d         = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule
